fcmp_arbiter: RTL
=================

Name: fcmp_arbiter

Overview:
- Shares one float-compare datapath (LT / EQ / LE on IEEE-754 single bit patterns) among NREQ requesters, e.g. the integer-pipe branch unit and the FPU issue slots.
- Round-robin arbitration, valid/ready request handshake, 2-stage pipeline, single tagged response channel with backpressure.
- Sits between the issue logic and the writeback/branch-resolve logic.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the requester tag.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_x1  in  NREQ*32  packed first operands; requester i at [32*i+31:32*i].
- req_x2  in  NREQ*32  packed second operands.
- req_op  in  NREQ*2  packed opcodes: 00 LT, 01 EQ, 10 LE, 11 reserved.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_y  out  1  compare result.
- resp_id  out  IDW  index of the requester that issued the result.
- in_flight  out  2  number of occupied pipeline stages (0..2).

Behaviour:
- Reset (async, rst=1): S1/S2 valids=0, rr pointer=0.
  - Outputs: resp_valid=0, resp_y=0, resp_id=0, req_ready=0, in_flight=0.
  - In-flight requests are dropped; no response is ever produced for them.
- Compare semantics (e=bits[30:23], s=bit31, em=bits[30:0]):
  - bz = (e1==0 && e2==0).
  - LT = ~bz && ((s1&~s2) | (s1&s2&em1>em2) | (~s1&~s2&em1<em2)).
  - EQ = bz | (x1==x2).
  - LE = LT | EQ.
  - op 11 -> y=0; the request is still consumed and answered.
  - No NaN handling.
- Arbitration:
  - Combinational. Grant = first i with req_valid[i]=1, scanning from ptr upward and wrapping modulo NREQ.
  - Grant never depends on resp_ready.
- Pipeline control:
  - adv2 = ~S2.v | resp_ready.
  - adv1 = ~S1.v | adv2.
  - req_ready[g] = adv1 for granted g; all other bits are 0. No grant means all 0.
- Request handshake:
  - Transfer occurs when req_valid[i] & req_ready[i].
  - Requester holds valid/operands/op stable until it transfers.
- Stage 1 (S1):
  - On transfer: registers x1, x2, op, id; S1.v=1.
  - On adv1 without transfer: S1.v=0.
  - On transfer: ptr <= g+1 mod NREQ.
- Stage 2 (S2):
  - On adv2: loads S1.v, the computed y, and id.
  - Outputs are driven from S2: resp_valid=S2.v, resp_y, resp_id.
- Latency and throughput:
  - Request accepted at edge N -> resp_valid high after edge N+1 (2 cycles), provided resp_ready was not low.
  - Throughput is one compare per cycle.
- Backpressure (resp_valid & ~resp_ready):
  - S2 holds; resp_y and resp_id stay stable.
  - S1 accepts only if empty. With both stages full, req_ready=0.
  - No loss, duplication or reordering of results.
- Simultaneous events:
  - A response handshake and a new acceptance in the same cycle both complete.
  - in_flight = S1.v + S2.v.
- Fairness: with all NREQ requesters valid continuously, each is granted exactly once per NREQ accepted transfers.

Test Plan:
- Only req0 valid (x1=0x3F800000, x2=0x40000000, LT), resp_ready=1, accepted at edge 0 -> resp_valid=1 after edge 1, resp_y=1, resp_id=0; next cycle resp_valid=0, in_flight=0.
- NREQ=4, all requesters continuously valid, resp_ready=1 -> acceptance order 0,1,2,3,0,1,...; resp_id sequence identical, delayed by 2 cycles; exactly one req_ready bit high each cycle.
- Continuous stream from req2, resp_ready=0 for 6 cycles -> exactly 2 accepted, then req_ready=0, in_flight=2, resp_y/resp_id frozen. Release -> all results delivered once, in order.
- Zero and sign cases:
  - LT(0x00000000, 0x80000000) -> 0.
  - EQ(0x00000000, 0x80000000) -> 1.
  - LT(0xBF800000, 0x00000000) -> 1.
  - LE(0x40000000, 0x40000000) -> 1.
  - LT(0xC0000000, 0xBF800000) -> 1.
  - op=11 on any operands -> response with y=0.
- Assert rst asynchronously mid-cycle with in_flight=2 -> resp_valid=0 immediately; after release, in_flight=0; with req1 and req3 valid, req1 is granted first (ptr=0).
- Grant pointer wrap: req3 granted, then only req0 and req2 valid -> req0 granted next, then req2.

Source files
------------

// File: rtl/fcmp_arbiter_if.sv
// fcmp_arbiter_if: request/response bundle between issue logic, the shared float comparator and writeback.
// Packed per-requester lanes: requester i owns x1/x2 bits [32*i+31:32*i] and op bits [2*i+1:2*i].
interface fcmp_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_x1;
    logic [NREQ*32-1:0] req_x2;
    logic [NREQ*2-1:0]  req_op;
    logic               resp_valid;
    logic               resp_ready;
    logic               resp_y;
    logic [IDW-1:0]     resp_id;
    logic [1:0]         in_flight;

    modport master (
        output req_valid, req_x1, req_x2, req_op, resp_ready,
        input  req_ready, resp_valid, resp_y, resp_id, in_flight
    );

    modport slave (
        input  req_valid, req_x1, req_x2, req_op, resp_ready,
        output req_ready, resp_valid, resp_y, resp_id, in_flight
    );
endinterface

// File: rtl/fcmp_arbiter.sv
// fcmp_arbiter: round-robin share of one float LT/EQ/LE comparator among NREQ requesters.
// Latency: 2 cycles from accept to resp_valid; one compare per cycle sustained.
// Backpressure: resp_ready low holds S2, S1 fills once more, then every req_ready drops.
module fcmp_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic          clk,
    input  logic          rst,
    fcmp_arbiter_if.slave bus
);

    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        OP_LT  = 2'b00,
        OP_EQ  = 2'b01,
        OP_LE  = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef struct packed {
        logic [31:0]    x1;
        logic [31:0]    x2;
        op_e            op;
        logic [IDW-1:0] id;
    } s1_t;

    // Both-zero-exponent operands compare equal regardless of sign or mantissa; NaNs are not special.
    function automatic logic fcmp(input logic [31:0] a, input logic [31:0] b, input op_e op);
        logic bz;
        logic lt;
        logic eq;
        logic y;
        bz = (a[30:23] == 8'd0) && (b[30:23] == 8'd0);
        lt = ~bz & ((a[31] & ~b[31])
                  | (a[31] & b[31] & (a[30:0] > b[30:0]))
                  | (~a[31] & ~b[31] & (a[30:0] < b[30:0])));
        eq = bz | (a == b);
        case (op)
            OP_LT:   y = lt;
            OP_EQ:   y = eq;
            OP_LE:   y = lt | eq;
            default: y = 1'b0;
        endcase
        return y;
    endfunction

    logic           s1_vld_q, s1_vld_d;
    s1_t            s1_q, s1_d;
    logic           s2_vld_q, s2_vld_d;
    logic           s2_y_q, s2_y_d;
    logic [IDW-1:0] s2_id_q, s2_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic           gnt_vld;
    logic [IDW-1:0] gnt_id;
    logic [31:0]    gnt_x1;
    logic [31:0]    gnt_x2;
    op_e            gnt_op;
    int             scan_off;
    int             best_off;

    logic           adv1;
    logic           adv2;
    logic           xfer;
    logic           s1_y;

    // Rotated priority: the valid requester at the smallest distance above ptr wins.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_id   = '0;
        best_off = NREQ;
        scan_off = 0;
        for (int i = 0; i < NREQ; i++) begin
            scan_off = (i + NREQ - int'(ptr_q)) % NREQ;
            if (bus.req_valid[i] && (scan_off < best_off)) begin
                best_off = scan_off;
                gnt_vld  = 1'b1;
                gnt_id   = IDW'(i);
            end
        end
    end

    always_comb begin
        gnt_x1 = '0;
        gnt_x2 = '0;
        gnt_op = OP_LT;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                gnt_x1 = bus.req_x1[i*32 +: 32];
                gnt_x2 = bus.req_x2[i*32 +: 32];
                gnt_op = op_e'(bus.req_op[i*2 +: 2]);
            end
        end
    end

    assign adv2 = ~s2_vld_q | bus.resp_ready;
    assign adv1 = ~s1_vld_q | adv2;
    // Accepting while reset is high would only be dropped, so ready is held low through reset.
    assign xfer = gnt_vld & adv1 & ~rst;
    assign s1_y = fcmp(s1_q.x1, s1_q.x2, s1_q.op);

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_ready[i] = xfer && (gnt_id == IDW'(i));
        end
    end

    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_d     = s1_q;
        s2_vld_d = s2_vld_q;
        s2_y_d   = s2_y_q;
        s2_id_d  = s2_id_q;
        ptr_d    = ptr_q;

        if (adv1) begin
            s1_vld_d = xfer;
        end
        if (xfer) begin
            s1_d.x1 = gnt_x1;
            s1_d.x2 = gnt_x2;
            s1_d.op = gnt_op;
            s1_d.id = gnt_id;
            ptr_d   = (gnt_id == LAST_ID) ? '0 : IDW'(gnt_id + 1'b1);
        end
        if (adv2) begin
            s2_vld_d = s1_vld_q;
            s2_y_d   = s1_y;
            s2_id_d  = s1_q.id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_q     <= '0;
            s2_vld_q <= 1'b0;
            s2_y_q   <= 1'b0;
            s2_id_q  <= '0;
            ptr_q    <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_q     <= s1_d;
            s2_vld_q <= s2_vld_d;
            s2_y_q   <= s2_y_d;
            s2_id_q  <= s2_id_d;
            ptr_q    <= ptr_d;
        end
    end

    assign bus.resp_valid = s2_vld_q;
    assign bus.resp_y     = s2_y_q;
    assign bus.resp_id    = s2_id_q;
    assign bus.in_flight  = {1'b0, s1_vld_q} + {1'b0, s2_vld_q};

endmodule
